// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced start/clear/lap buttons drive a stopwatch FSM emitting tenth-second ticks
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       display_hold,
  output logic       running,
  output logic [1:0] state
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSED = 2'b10, LAP = 2'b11} state_t;
  state_t st, nxt;
  logic [2:0] btn, s1, s2, lvl, lvl_q, prs;
  logic [2:0][DW-1:0] dcnt;
  logic [TW-1:0] tc;
  logic clr_ev, start_ev, lap_ev, do_clr, keep, live;
  assign btn = {btn_lap, btn_start, btn_clear};
  assign {lap_ev, start_ev, clr_ev} = prs;
  assign state = st;
  assign live = st == RUN || st == LAP;
  always_comb begin
    do_clr = clr_ev && (st == IDLE || st == PAUSED);
    nxt = do_clr ? IDLE :
          start_ev ? (live ? PAUSED : RUN) :
          (lap_ev && st == RUN) ? LAP :
          (lap_ev && st == LAP) ? RUN : st;
    keep = live && (nxt == RUN || nxt == LAP);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      lvl <= '0;
      lvl_q <= '0;
      prs <= '0;
      dcnt <= '0;
      st <= IDLE;
      tc <= '0;
      cnt_en <= 1'b0;
      cnt_clr <= 1'b0;
      display_hold <= 1'b0;
      running <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      lvl_q <= lvl;
      prs <= lvl & ~lvl_q;
      for (int i = 0; i < 3; i++) begin
        dcnt[i] <= (s2[i] == lvl[i] || dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : dcnt[i] + 1'b1;
        if (s2[i] != lvl[i] && dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) lvl[i] <= s2[i];
      end
      st <= nxt;
      tc <= do_clr ? '0 : keep ? (tc == TW'(TICK_DIV - 1) ? '0 : tc + 1'b1) : tc;
      cnt_en <= keep && tc == TW'(TICK_DIV - 1);
      cnt_clr <= do_clr;
      display_hold <= nxt == LAP;
      running <= nxt == RUN || nxt == LAP;
    end
  end
endmodule
